// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : sizing and pointer-wrap helpers shared by the sync_fifo files.
// Revision : 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int c_MIN_DEPTH = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_ram : register array, one write port, one combinational read port.
// Revision : 1.0
// ---------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 45
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [ptr_w(DEPTH)-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0]       o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, any depth >= 2, optional FWFT, flush, sticky errors.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 45,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        flush,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    input  logic                        clr_err,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int              c_CW       = cnt_w(DEPTH);
    localparam int              c_PW       = ptr_w(DEPTH);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_CNT   = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE_CNT   = c_CW'(AE_LEVEL);

    if (DEPTH < c_MIN_DEPTH) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_chk_af
        $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_chk_ae
        $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_chk_fwft
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_ready;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_op_ok;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_err;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);

    // r_ready stays low through the first edge after reset release, so that
    // edge never accepts an operation.
    assign w_op_ok  = r_ready && !flush;
    assign w_wr_acc = w_op_ok && w_en && !w_full;
    assign w_rd_acc = w_op_ok && r_en && !w_empty;
    assign w_wr_err = w_op_ok && w_en && w_full;
    assign w_rd_err = w_op_ok && r_en && w_empty;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ready  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_ready <= 1'b1;
            if (r_ready && flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= c_PW'(next_ptr(int'(r_wr_ptr), DEPTH));
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= c_PW'(next_ptr(int'(r_rd_ptr), DEPTH));
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_count <= r_count + c_CW'(1);
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end
    end

    // A new error in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_wr_err) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_rd_err) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign data_out = w_empty ? '0 : w_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                r_dout <= '0;
            end else if (w_rd_acc) begin
                r_dout <= w_rdata;
            end
        end

        assign data_out = r_dout;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_CNT);
    assign almost_empty = (r_count <= c_AE_CNT);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// Bench for sync_fifo: vector table, directed corner sequences, randomized
// traffic against a queue model; a second instance covers FWFT mode.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 45;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic          a_flush = 1'b0, a_w_en = 1'b0, a_r_en = 1'b0, a_clr = 1'b0;
    logic [DW-1:0] a_din = '0, a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [CW-1:0] a_count;

    logic          b_flush = 1'b0, b_w_en = 1'b0, b_r_en = 1'b0, b_clr = 1'b0;
    logic [DW-1:0] b_din = '0, b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [CW-1:0] b_count;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .arstn(arstn), .flush(a_flush), .w_en(a_w_en), .data_in(a_din),
        .r_en(a_r_en), .clr_err(a_clr), .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .arstn(arstn), .flush(b_flush), .w_en(b_w_en), .data_in(b_din),
        .r_en(b_r_en), .clr_err(b_clr), .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model: contents as a plain queue plus the observable registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf = 1'b0, m_udf = 1'b0;
    int            m_wr_tot = 0, m_rd_tot = 0;
    int            wr_wraps = 0, rd_wraps = 0;

    task automatic compare_a(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, " count"}, int'(a_count), sz);
        chk({tag, " empty"}, int'(a_empty), int'(sz == 0));
        chk({tag, " full"},  int'(a_full),  int'(sz == DEPTH));
        chk({tag, " af"},    int'(a_af),    int'(sz >= AF));
        chk({tag, " ae"},    int'(a_ae),    int'(sz <= AE));
        chk({tag, " dout"},  int'(a_dout),  int'(m_dout));
        chk({tag, " ovf"},   int'(a_ovf),   int'(m_ovf));
        chk({tag, " udf"},   int'(a_udf),   int'(m_udf));
    endtask

    task automatic step(input bit w, input bit r, input bit fl, input bit clr,
                        input logic [DW-1:0] din, input string tag);
        int sz;
        int pw0, pr0;
        sz  = mq.size();
        pw0 = int'(u_std.r_wr_ptr);
        pr0 = int'(u_std.r_rd_ptr);
        a_w_en = w; a_r_en = r; a_flush = fl; a_clr = clr; a_din = din;
        @(posedge clk); #1;
        a_w_en = 1'b0; a_r_en = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
        if (pw0 == DEPTH - 1 && int'(u_std.r_wr_ptr) == 0) wr_wraps++;
        if (pr0 == DEPTH - 1 && int'(u_std.r_rd_ptr) == 0) rd_wraps++;
        if (!fl && w && sz == DEPTH) m_ovf = 1'b1;
        else if (clr)                m_ovf = 1'b0;
        if (!fl && r && sz == 0)     m_udf = 1'b1;
        else if (clr)                m_udf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (r && sz > 0)     begin m_dout = mq.pop_front(); m_rd_tot++; end
            if (w && sz < DEPTH) begin mq.push_back(din);      m_wr_tot++; end
        end
        compare_a(tag);
    endtask

    // Reset is asserted between edges and checked before any further edge.
    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        arstn = 1'b0;
        #1;
        mq.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        compare_a(tag);
        chk({tag, " b_empty"}, int'(b_empty), 1);
        chk({tag, " b_dout"},  int'(b_dout),  0);
        @(posedge clk); #1;
        arstn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, "post_rst0");
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, "post_rst1");
    endtask

    task automatic b_tick(input bit w, input bit r, input logic [DW-1:0] din);
        b_w_en = w; b_r_en = r; b_din = din;
        @(posedge clk); #1;
        b_w_en = 1'b0; b_r_en = 1'b0;
    endtask

    typedef struct {
        bit            w, r, fl, clr;
        logic [DW-1:0] din;
        int            cnt;
        bit            emp;
        logic [DW-1:0] dout;
        bit            ovf, udf;
    } vec_t;

    vec_t tbl [13];

    initial begin
        //           w     r     fl    clr   din    cnt emp   dout   ovf   udf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1, 1'b0, 8'h22, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1, 1'b0, 8'h33, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b0};

        do_reset("reset");

        foreach (tbl[i]) begin
            a_w_en = tbl[i].w; a_r_en = tbl[i].r; a_flush = tbl[i].fl;
            a_clr = tbl[i].clr; a_din = tbl[i].din;
            @(posedge clk); #1;
            a_w_en = 1'b0; a_r_en = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
            chk($sformatf("vec%0d count", i), int'(a_count), tbl[i].cnt);
            chk($sformatf("vec%0d empty", i), int'(a_empty), int'(tbl[i].emp));
            chk($sformatf("vec%0d dout", i),  int'(a_dout),  int'(tbl[i].dout));
            chk($sformatf("vec%0d ovf", i),   int'(a_ovf),   int'(tbl[i].ovf));
            chk($sformatf("vec%0d udf", i),   int'(a_udf),   int'(tbl[i].udf));
        end

        // Fill to full, then one write too many.
        do_reset("reset2");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i), "fill");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, "fill_ovf");
        chk("fill_ovf count45", int'(a_count), 45);

        // Drain, then one read too many.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "drain");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, "drain_udf");
        chk("drain_udf dout_hold", int'(a_dout), 8'h2C);

        // Simultaneous read/write at full and at count 10.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, "clr");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h40 + i), "refill");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, "rw_full");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEF, "wr_after_full");
        for (int i = 0; i < 35; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "down10");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, "rw_10");
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "order");

        // Flush at count 20 with overflow still sticky, then reset mid-operation.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h80 + i), "fill20");
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h99, "flush_w");
        chk("flush keeps ovf", int'(a_ovf), 1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hA0 + i), "fill20b");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, "pre_rst_rd");

        // FWFT instance.
        b_tick(1'b1, 1'b0, 8'hA5);
        chk("fwft first dout", int'(b_dout), 8'hA5);
        chk("fwft first empty", int'(b_empty), 0);
        b_tick(1'b0, 1'b1, '0);
        chk("fwft pop empty", int'(b_empty), 1);
        chk("fwft pop dout0", int'(b_dout), 0);
        b_tick(1'b1, 1'b0, 8'h11);
        b_tick(1'b1, 1'b0, 8'h22);
        chk("fwft head", int'(b_dout), 8'h11);
        chk("fwft count2", int'(b_count), 2);
        b_tick(1'b0, 1'b1, '0);
        chk("fwft next", int'(b_dout), 8'h22);
        b_tick(1'b0, 1'b1, '0);
        b_tick(1'b0, 1'b1, '0);
        chk("fwft udf", int'(b_udf), 1);
        chk("fwft empty dout", int'(b_dout), 0);
        chk("fwft flags", int'({b_full, b_af, b_ae, b_ovf}), 4'b0010);
        b_clr = 1'b1; b_flush = 1'b1;
        b_tick(1'b0, 1'b0, '0);
        b_clr = 1'b0; b_flush = 1'b0;
        chk("fwft clr", int'(b_udf), 0);

        do_reset("midop_reset");

        // Randomized interleaved traffic.
        wr_wraps = 0; rd_wraps = 0; m_wr_tot = 0; m_rd_tot = 0;
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 9) < 9), ($urandom_range(0, 9) < 8), 1'b0,
                 ($urandom_range(0, 15) == 0), DW'($urandom), "rand");
        end
        chk("rand wr_wraps", wr_wraps, m_wr_tot / DEPTH);
        chk("rand rd_wraps", rd_wraps, m_rd_tot / DEPTH);
        chk("rand wraps>=4", int'(wr_wraps + rd_wraps >= 4), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
